multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_seq.sv | 168 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_seq
// Description : Sequential signed 32x32 multiplier / 32/32 divider. Works on
//               operand magnitudes with one radix-2 step per cycle, then fixes
//               the signs and writes the HI/LO result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        HIWrite,
  output logic        LOWrite
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiplicand magnitude (MULT) or divisor magnitude (DIV)
  logic [31:0] m_q, m_d;
  // MULT: {partial product high, remaining multiplier bits}
  // DIV : {partial remainder, dividend bits shifting into quotient}
  logic [63:0] acc_q, acc_d;
  logic        op_div_q, op_div_d;
  logic        neg_q, neg_d;       // operand signs differ
  logic        a_neg_q, a_neg_d;   // dividend sign, for the remainder
  logic        dz_q, dz_d;         // current completion is a divide-by-zero
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic        b_zero;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign a_mag  = a_in[31] ? (32'd0 - a_in) : a_in;
  assign b_mag  = b_in[31] ? (32'd0 - b_in) : b_in;
  assign b_zero = (b_in == 32'd0);

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits and record the quotient bit.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign div_diff  = div_shift[31:0] - m_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};

  // Sign correction applied while in FIX
  assign prod_fix = neg_q   ? (64'd0 - acc_q)         : acc_q;
  assign quo_fix  = neg_q   ? (32'd0 - acc_q[31:0])   : acc_q[31:0];
  assign rem_fix  = a_neg_q ? (32'd0 - acc_q[63:32])  : acc_q[63:32];

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_d    = acc_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_div_d = op_div;
          neg_d    = a_in[31] ^ b_in[31];
          a_neg_d  = a_in[31];
          cnt_d    = 5'd0;
          dz_d     = op_div && b_zero;
          if (op_div) begin
            m_d   = b_mag;
            acc_d = {32'd0, a_mag};
          end else begin
            m_d   = a_mag;
            acc_d = {32'd0, b_mag};
          end
          state_d = (op_div && b_zero) ? DONE : CALC;
        end
      end
      CALC: begin
        acc_d = op_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      m_q      <= 32'd0;
      acc_q    <= 64'd0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign div_zero = done && dz_q;
  assign HIWrite  = done && !dz_q;
  assign LOWrite  = done && !dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_seq
// Description : Directed self-checking bench for multdiv_seq with a result
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy, done, div_zero, HIWrite, LOWrite;
  logic [31:0] hi_out, lo_out;

  multdiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_div   (op_div),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .HIWrite  (HIWrite),
    .LOWrite  (LOWrite)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_done = 0;
  int          n_exp_done = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  // Count every completion pulse seen on a clock edge
  always @(posedge clk) begin
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Wait (bounded) for done, then check latency, busy, strobes and results.
  task automatic wait_done(input string tag, input int g_at, input bit poke_done);
    int   lat  = 0;
    int   bcnt = 0;
    exp_t e;
    while (done !== 1'b1 && lat < 80) begin
      if (busy === 1'b1) bcnt++;
      if (lat == g_at) begin
        start = 1'b1; op_div = 1'b0; a_in = 32'd100; b_in = 32'd100;
      end else if (lat == g_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    n_exp_done++;
    chk({tag, " latency"}, 64'(lat), e.dz ? 64'd0 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(bcnt), e.dz ? 64'd0 : 64'd33);
    chk({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
    chk({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
    chk({tag, " strobes"}, {62'd0, HIWrite, LOWrite}, e.dz ? 64'd0 : 64'd3);
    chk({tag, " hi_lo"}, {hi_out, lo_out}, {e.hi, e.lo});
    if (poke_done) begin
      start = 1'b1; op_div = 1'b0; a_in = 32'd9; b_in = 32'd9;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " after_done"}, {62'd0, done, busy}, 64'd0);
    chk({tag, " hold_hi_lo"}, {hi_out, lo_out}, {e.hi, e.lo});
  endtask

  // Issue one operation from a negedge in IDLE and verify it.
  task automatic do_op(input string tag, input bit op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_e, input logic [31:0] lo_e,
                       input int g_at, input bit poke_done);
    exp_t e;
    e.dz = op && (b == 32'd0);
    e.hi = e.dz ? last_hi : hi_e;
    e.lo = e.dz ? last_lo : lo_e;
    sb.push_back(e);
    start = 1'b1; op_div = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = $urandom; b_in = $urandom; op_div = ~op;
    wait_done(tag, g_at, poke_done);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_div = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {57'd0, busy, done, div_zero, HIWrite, LOWrite, 2'b00},
        64'd0);
    chk("reset_hi_lo", {hi_out, lo_out}, 64'd0);
    // start asserted during reset must be overridden
    start = 1'b1; op_div = 1'b0; a_in = 32'd3; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("reset_overrides_start", {62'd0, busy, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op("mul_7_m3",    1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, -1, 1'b0);
    do_op("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, -1, 1'b0);
    do_op("div_preload", 1'b1, 32'h12345678, 32'h7FFFFFFF, 32'h12345678, 32'h00000000, -1, 1'b0);
    do_op("div_5_0",     1'b1, 32'd5,        32'd0,        32'h0,        32'h0,        -1, 1'b0);
    do_op("div_min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, -1, 1'b0);
    do_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, -1, 1'b0);
    do_op("mul_3_4_ign", 1'b0, 32'd3,        32'd4,        32'h00000000, 32'd12,        5, 1'b1);
    do_op("div_100_m7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, -1, 1'b0);
    do_op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       -1, 1'b0);
    do_op("mul_m5_m6",   1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30,       -1, 1'b0);

    // Abort an operation with reset in the middle of CALC
    start = 1'b1; op_div = 1'b0; a_in = 32'd1000; b_in = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    chk("abort_hi_lo", {hi_out, lo_out}, 64'd0);
    last_hi = 32'd0;
    last_lo = 32'd0;
    reset = 1'b1;
    do_op("mul_after_rst", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("done_pulse_count", 64'(n_done), 64'(n_exp_done));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
